// File: rtl/clk_enable_sched.sv
// Shared clock-enable scheduler: per-channel divisor counters with tick pulses, optional phase outputs,
// run/stop FSM and shadowed divisor updates. Define PHASE_OUT_EN to build the phase toggle flops.
module clk_enable_sched #(
  parameter int              NCH         = 4,
  parameter int              CW          = 32,
  parameter int              SELW        = 2,
  parameter logic [CW-1:0]   DEFAULT_DIV = 100
) (
  input  logic             CLK_IN,
  input  logic             clr,
  input  logic             run,
  input  logic             cfg_we,
  input  logic [SELW-1:0]  cfg_sel,
  input  logic [CW-1:0]    cfg_div,
  output logic             cfg_ack,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   phase,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

  state_t state_q, state_d;
  logic   busy_q;
  logic   ack_q;
  logic   counting;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (run) state_d = SYNC;
      SYNC:    state_d = run ? RUN : IDLE;
      RUN:     if (!run) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Channels only advance while running and not being stopped this edge.
  assign counting = (state_q == RUN) && run;

  always_ff @(posedge CLK_IN or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      ack_q   <= cfg_we;
    end
  end

  assign busy    = busy_q;
  assign cfg_ack = ack_q;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] div_q, div_d;
    logic [CW-1:0] shadow_q, shadow_d;
    logic          pend_q, pend_d;
    logic          tick_q, tick_d;
    logic          term;
    logic          wr;

    assign wr   = cfg_we && (cfg_sel == SELW'(gi));
    assign term = counting && (cnt_q == div_q);

    always_comb begin
      cnt_d    = '0;
      div_d    = div_q;
      shadow_d = shadow_q;
      pend_d   = pend_q;
      tick_d   = 1'b0;
      if (counting) begin
        cnt_d  = term ? '0 : cnt_q + CW'(1);
        tick_d = term;
      end
      if (term) begin
        div_d  = pend_q ? shadow_q : div_q;
        pend_d = 1'b0;
      end
      // Outside RUN, or on the terminal edge itself, a write takes effect at once.
      if (wr) begin
        shadow_d = cfg_div;
        if ((state_q != RUN) || term) begin
          div_d  = cfg_div;
          pend_d = 1'b0;
        end else begin
          pend_d = 1'b1;
        end
      end
    end

    always_ff @(posedge CLK_IN or posedge clr) begin
      if (clr) begin
        cnt_q    <= '0;
        div_q    <= DEFAULT_DIV;
        shadow_q <= DEFAULT_DIV;
        pend_q   <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        div_q    <= div_d;
        shadow_q <= shadow_d;
        pend_q   <= pend_d;
        tick_q   <= tick_d;
      end
    end

    assign tick[gi] = tick_q;

`ifdef PHASE_OUT_EN
    logic phase_q;
    always_ff @(posedge CLK_IN or posedge clr) begin
      if (clr) begin
        phase_q <= 1'b0;
      end else if (!counting) begin
        phase_q <= 1'b0;
      end else if (term) begin
        phase_q <= ~phase_q;
      end
    end
    assign phase[gi] = phase_q;
`else
    assign phase[gi] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_clk_enable_sched.sv
// Randomized and directed bench for clk_enable_sched against a tick-schedule reference model.
module tb_clk_enable_sched;
  localparam int            NCH  = 3;
  localparam int            CW   = 8;
  localparam int            SELW = 2;
  localparam logic [CW-1:0] DEF  = 8'd100;

  logic            CLK_IN = 1'b0;
  logic            clr;
  logic            run;
  logic            cfg_we;
  logic [SELW-1:0] cfg_sel;
  logic [CW-1:0]   cfg_div;
  logic            cfg_ack;
  logic [NCH-1:0]  tick;
  logic [NCH-1:0]  phase;
  logic            busy;

  clk_enable_sched #(.NCH(NCH), .CW(CW), .SELW(SELW), .DEFAULT_DIV(DEF)) dut (
    .CLK_IN(CLK_IN), .clr(clr), .run(run), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_div(cfg_div), .cfg_ack(cfg_ack), .tick(tick), .phase(phase), .busy(busy)
  );

  always #5 CLK_IN = ~CLK_IN;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: each channel keeps the absolute edge index of its next terminal count.
  int             n;
  int             m_state;  // 0 stopped, 1 aligning, 2 running
  int             m_div[NCH];
  int             m_shadow[NCH];
  int             m_next[NCH];
  bit             m_pend[NCH];
  logic [NCH-1:0] e_tick;
  logic [NCH-1:0] e_phase;
  logic           e_ack;
  logic           e_busy;

  // Observed tick history for period measurements.
  int tlog[NCH][8];
  int tcnt[NCH];
  int plog[8];
  int pcnt;
  logic prev_ph0;

  function automatic logic [NCH-1:0] exp_phase();
`ifdef PHASE_OUT_EN
    return e_phase;
`else
    return '0;
`endif
  endfunction

  task automatic model_reset();
    m_state = 0;
    for (int i = 0; i < NCH; i++) begin
      m_div[i] = DEF; m_shadow[i] = DEF; m_pend[i] = 0; m_next[i] = 0;
    end
    e_tick = '0; e_phase = '0; e_ack = 0; e_busy = 0;
  endtask

  task automatic model_edge(input bit r, input bit we, input int sel, input int d);
    bit active;
    int ns;
    active = (m_state == 2) && r;
    for (int i = 0; i < NCH; i++) begin
      bit term;
      term = active && (n == m_next[i]);
      e_tick[i] = term;
      if (!active) e_phase[i] = 1'b0;
      else if (term) e_phase[i] = ~e_phase[i];
      if (term) begin
        if (m_pend[i]) m_div[i] = m_shadow[i];
        m_pend[i] = 0;
      end
      if (we && sel == i) begin
        m_shadow[i] = d;
        if (m_state != 2 || term) begin m_div[i] = d; m_pend[i] = 0; end
        else m_pend[i] = 1;
      end
      if (term) m_next[i] = n + m_div[i] + 1;
    end
    e_ack = we;
    ns = m_state;
    case (m_state)
      0: if (r) ns = 1;
      1: begin
        ns = r ? 2 : 0;
        if (r) for (int i = 0; i < NCH; i++) m_next[i] = n + 1 + m_div[i];
      end
      default: if (!r) ns = 0;
    endcase
    m_state = ns;
    e_busy = (ns != 0);
  endtask

  task automatic clear_logs();
    for (int i = 0; i < NCH; i++) tcnt[i] = 0;
    pcnt = 0;
  endtask

  task automatic step(input bit r, input bit we, input logic [SELW-1:0] sel, input logic [CW-1:0] d);
    int e;
    run = r; cfg_we = we; cfg_sel = sel; cfg_div = d;
    @(posedge CLK_IN);
    e = n;
    model_edge(r, we, int'(sel), int'(d));
    n++;
    #1;
    for (int i = 0; i < NCH; i++)
      if (tick[i] === 1'b1 && tcnt[i] < 8) begin tlog[i][tcnt[i]] = e; tcnt[i]++; end
    if (phase[0] === 1'b1 && prev_ph0 !== 1'b1 && pcnt < 8) begin plog[pcnt] = e; pcnt++; end
    prev_ph0 = phase[0];
    if (we) $display("edge %0d write sel=%0d div=%0d run=%0b", e, sel, d, r);
    check("tick", 32'(tick), 32'(e_tick));
    check("phase", 32'(phase), 32'(exp_phase()));
    check("ack", 32'(cfg_ack), 32'(e_ack));
    check("busy", 32'(busy), 32'(e_busy));
  endtask

  int k;
  logic ph_prev;

  initial begin
    clr = 1'b1; run = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_div = '0;
    n = 0; prev_ph0 = 1'b0;
    model_reset();
    clear_logs();
    repeat (3) @(posedge CLK_IN);
    #2 clr = 1'b0;
    check("rst_tick", 32'(tick), 0);
    check("rst_busy", 32'(busy), 0);

    // Run briefly, then reset mid-cycle with run still high.
    repeat (30) step(1, 0, 0, 0);
    #2 clr = 1'b1;
    #1;
    check("clr_tick", 32'(tick), 0);
    check("clr_phase", 32'(phase), 0);
    check("clr_busy", 32'(busy), 0);
    check("clr_ack", 32'(cfg_ack), 0);
    model_reset();
    @(posedge CLK_IN);
    #2 clr = 1'b0;

    // Default divisor: first tick at k+102, period 101, phase period 202.
    clear_logs();
    k = n;
    repeat (310) step(1, 0, 0, 0);
    check("def_first", tlog[0][0] - k, 102);
    check("def_period", tlog[0][1] - tlog[0][0], 101);
`ifdef PHASE_OUT_EN
    check("def_phase_period", plog[1] - plog[0], 202);
`endif

    // Alignment: ch0 D=3, ch1 D=1 written while stopped.
    step(0, 0, 0, 0);
    step(0, 1, 0, 8'd3);
    step(0, 1, 1, 8'd1);
    clear_logs();
    k = n;
    step(1, 0, 0, 0);
    check("align_busy", 32'(busy), 1);
    repeat (12) step(1, 0, 0, 0);
    check("align_first0", tlog[0][0] - k, 5);
    check("align_first1", tlog[1][0] - k, 3);
    check("align_per0", tlog[0][1] - tlog[0][0], 4);
    check("align_per1", tlog[1][1] - tlog[1][0], 2);

    // Shadow update: ch0 D=9, write D=2 mid-period.
    step(0, 0, 0, 0);
    step(0, 1, 0, 8'd9);
    clear_logs();
    step(1, 0, 0, 0);
    for (int j = 0; j < 40 && tcnt[0] == 0; j++) step(1, 0, 0, 0);
    check("sh_first_seen", tcnt[0], 1);
    repeat (3) step(1, 0, 0, 0);
    step(1, 1, 0, 8'd2);
    check("sh_ack_hi", 32'(cfg_ack), 1);
    step(1, 0, 0, 0);
    check("sh_ack_lo", 32'(cfg_ack), 0);
    repeat (16) step(1, 0, 0, 0);
    check("sh_old_period", tlog[0][1] - tlog[0][0], 10);
    check("sh_new_period", tlog[0][2] - tlog[0][1], 3);

    // Write landing on ch2's terminal edge is applied immediately.
    step(0, 0, 0, 0);
    step(0, 1, 2, 8'd4);
    clear_logs();
    k = n;
    step(1, 0, 0, 0);
    repeat (5) step(1, 0, 0, 0);
    step(1, 1, 2, 8'd5);
    repeat (14) step(1, 0, 0, 0);
    check("byp_first", tlog[2][0] - k, 6);
    check("byp_period1", tlog[2][1] - tlog[2][0], 6);
    check("byp_period2", tlog[2][2] - tlog[2][1], 6);

    // D=0 on ch2: tick held high, phase toggling; then stop.
    step(0, 0, 0, 0);
    step(0, 1, 2, 8'd0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    ph_prev = phase[2];
    for (int j = 0; j < 5; j++) begin
      step(1, 0, 0, 0);
      check("d0_tick", 32'(tick[2]), 1);
`ifdef PHASE_OUT_EN
      check("d0_phase_toggle", 32'(phase[2]), 32'(~ph_prev));
`endif
      ph_prev = phase[2];
    end
    step(0, 0, 0, 0);
    check("stop_tick", 32'(tick), 0);
    check("stop_phase", 32'(phase), 0);
    check("stop_busy", 32'(busy), 0);

    // Out-of-range select: acknowledged, no channel affected (model tracks the rest).
    step(0, 1, 2'd3, 8'd1);
    check("inv_ack", 32'(cfg_ack), 1);

    // Randomized traffic.
    for (int j = 0; j < 3000; j++) begin
      bit r;
      bit we;
      logic [SELW-1:0] sel;
      logic [CW-1:0] d;
      r   = ($urandom_range(0, 99) < 97);
      we  = ($urandom_range(0, 9) == 0);
      sel = SELW'($urandom_range(0, 3));
      d   = ($urandom_range(0, 19) == 0) ? 8'd255 : CW'($urandom_range(0, 12));
      step(r, we, sel, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
